// File: rtl/cu_pkg.sv
// Shared types and instruction-field layout for the multi-cycle control unit.
package cu_pkg;

  typedef enum logic [1:0] {
    CLS_NOP   = 2'b00,
    CLS_STD   = 2'b01,
    CLS_LOAD  = 2'b10,
    CLS_STORE = 2'b11
  } cls_e;

  typedef enum logic [4:0] {
    S_IDLE       = 5'b00001,
    S_DECODE     = 5'b00010,
    S_EXECUTE    = 5'b00100,
    S_MEM_ACCESS = 5'b01000,
    S_WRITE_BACK = 5'b10000
  } state_e;

  localparam int unsigned OPC_WIDTH = 4;
  localparam int unsigned CLS_WIDTH = 2;
  localparam int unsigned OFF_LSB   = OPC_WIDTH;
  localparam logic [3:0]  OPC_IDLE  = 4'hF;

  // Field LSB positions; word is class|dest|src1|src2|offset|opcode, MSB first.
  function automatic int unsigned src2_lsb(input int unsigned dw);
    return OPC_WIDTH + dw;
  endfunction

  function automatic int unsigned src1_lsb(input int unsigned dw, input int unsigned ra);
    return OPC_WIDTH + dw + ra;
  endfunction

  function automatic int unsigned dest_lsb(input int unsigned dw, input int unsigned ra);
    return OPC_WIDTH + dw + 2 * ra;
  endfunction

  function automatic int unsigned cls_lsb(input int unsigned dw, input int unsigned ra);
    return OPC_WIDTH + dw + 3 * ra;
  endfunction

  function automatic int unsigned instr_width(input int unsigned dw, input int unsigned ra);
    return CLS_WIDTH + OPC_WIDTH + dw + 3 * ra;
  endfunction

endpackage

// File: rtl/cu_multicycle_ctrl_if.sv
// Instruction handshake, write-back data and datapath-control bundle of the control unit.
interface cu_multicycle_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_REGS   = 4
);
  import cu_pkg::*;

  localparam int unsigned RA_BITS     = $clog2(NUM_REGS);
  localparam int unsigned INSTR_WIDTH = instr_width(DATA_WIDTH, RA_BITS);

  logic                   instr_valid;
  logic [INSTR_WIDTH-1:0] instr;
  logic                   instr_ready;
  logic [DATA_WIDTH-1:0]  result2;
  logic [DATA_WIDTH-1:0]  operand1;
  logic [DATA_WIDTH-1:0]  operand2;
  logic [DATA_WIDTH-1:0]  offset;
  logic [3:0]             opcode;
  logic                   sel1;
  logic                   sel3;
  logic                   w_r;
  logic                   busy;
  logic                   retire;

  modport master (
    output instr_valid, instr, result2,
    input  instr_ready, operand1, operand2, offset, opcode, sel1, sel3, w_r, busy, retire
  );

  modport slave (
    input  instr_valid, instr, result2,
    output instr_ready, operand1, operand2, offset, opcode, sel1, sel3, w_r, busy, retire
  );

endinterface

// File: rtl/cu_regfile.sv
// Register file: two async read ports, one sync write port, reset to reg[i]=i.
// Optional CU_REGDBG_EN adds a side-effect-free async debug read port.
module cu_regfile #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_REGS   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [$clog2(NUM_REGS)-1:0] ra1,
  output logic [DATA_WIDTH-1:0]       rd1,
  input  logic [$clog2(NUM_REGS)-1:0] ra2,
  output logic [DATA_WIDTH-1:0]       rd2,
  input  logic                        we,
  input  logic [$clog2(NUM_REGS)-1:0] wa,
  input  logic [DATA_WIDTH-1:0]       wd
`ifdef CU_REGDBG_EN
  ,
  input  logic [$clog2(NUM_REGS)-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0]       dbg_data
`endif
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= DATA_WIDTH'(i);
    end else if (we) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = regs[ra1];
  assign rd2 = regs[ra2];

`ifdef CU_REGDBG_EN
  assign dbg_data = regs[dbg_addr];
`endif

endmodule

// File: rtl/cu_multicycle_ctrl.sv
// Multi-cycle control unit: IDLE->DECODE->EXECUTE->[MEM_ACCESS]->WRITE_BACK sequencer
// with registered datapath controls. CU_REGDBG_EN exposes a register-file debug read port.
module cu_multicycle_ctrl
  import cu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_REGS   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  cu_multicycle_ctrl_if.slave         bus
`ifdef CU_REGDBG_EN
  ,
  input  logic [$clog2(NUM_REGS)-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0]       dbg_data
`endif
);

  localparam int unsigned RA_BITS     = $clog2(NUM_REGS);
  localparam int unsigned INSTR_WIDTH = instr_width(DATA_WIDTH, RA_BITS);
  localparam int unsigned SRC2_LSB    = src2_lsb(DATA_WIDTH);
  localparam int unsigned SRC1_LSB    = src1_lsb(DATA_WIDTH, RA_BITS);
  localparam int unsigned DEST_LSB    = dest_lsb(DATA_WIDTH, RA_BITS);
  localparam int unsigned CLS_LSB     = cls_lsb(DATA_WIDTH, RA_BITS);

  state_e                 state_q, state_d;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic                   accept;
  logic                   we;

  cls_e                   cls_q, cls_in;
  logic [RA_BITS-1:0]     dest_q, src1_q, src2_q, ra2;
  logic [DATA_WIDTH-1:0]  rd1, rd2, off_f;
  logic [3:0]             opc_f;

  logic [DATA_WIDTH-1:0]  op1_q, op1_d, op2_q, op2_d, off_q, off_d;
  logic [3:0]             opc_q, opc_d;
  logic                   sel1_q, sel1_d, sel3_q, sel3_d, w_r_q, w_r_d;
  logic                   retire_q, retire_d, ready_q, ready_d, busy_q;

  assign cls_q  = cls_e'(instr_q[CLS_LSB +: CLS_WIDTH]);
  assign cls_in = cls_e'(bus.instr[CLS_LSB +: CLS_WIDTH]);
  assign dest_q = instr_q[DEST_LSB +: RA_BITS];
  assign src1_q = instr_q[SRC1_LSB +: RA_BITS];
  assign src2_q = instr_q[SRC2_LSB +: RA_BITS];
  assign off_f  = instr_q[OFF_LSB +: DATA_WIDTH];
  assign opc_f  = instr_q[0 +: OPC_WIDTH];
  // Memory-class instructions read the z/dest register on the second port.
  assign ra2    = (cls_q == CLS_STD) ? src2_q : dest_q;

  cu_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .ra1      (src1_q),
    .rd1      (rd1),
    .ra2      (ra2),
    .rd2      (rd2),
    .we       (we),
    .wa       (dest_q),
    .wd       (bus.result2)
`ifdef CU_REGDBG_EN
    ,
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
`endif
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    we       = 1'b0;
    op1_d    = op1_q;
    op2_d    = op2_q;
    off_d    = off_q;
    opc_d    = opc_q;
    sel1_d   = sel1_q;
    sel3_d   = sel3_q;
    w_r_d    = 1'b0;
    retire_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.instr_valid) begin
          accept   = 1'b1;
          state_d  = S_DECODE;
          retire_d = (cls_in == CLS_NOP);
        end
      end
      S_DECODE: begin
        if (cls_q == CLS_NOP) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_EXECUTE;
          op1_d   = rd1;
          op2_d   = rd2;
          off_d   = off_f;
          opc_d   = opc_f;
          sel1_d  = (cls_q != CLS_LOAD);
          sel3_d  = (cls_q != CLS_STD);
        end
      end
      S_EXECUTE: begin
        if (cls_q == CLS_STD) begin
          state_d  = S_WRITE_BACK;
          retire_d = 1'b1;
        end else begin
          state_d = S_MEM_ACCESS;
          w_r_d   = (cls_q == CLS_STORE);
        end
      end
      S_MEM_ACCESS: begin
        state_d  = S_WRITE_BACK;
        retire_d = 1'b1;
      end
      S_WRITE_BACK: begin
        state_d = S_IDLE;
        we      = (cls_q == CLS_STD) || (cls_q == CLS_LOAD);
        op1_d   = '0;
        op2_d   = '0;
        off_d   = '0;
        opc_d   = OPC_IDLE;
        sel1_d  = 1'b0;
        sel3_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        op1_d   = '0;
        op2_d   = '0;
        off_d   = '0;
        opc_d   = OPC_IDLE;
        sel1_d  = 1'b0;
        sel3_d  = 1'b0;
      end
    endcase

    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      instr_q  <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      off_q    <= '0;
      opc_q    <= OPC_IDLE;
      sel1_q   <= 1'b0;
      sel3_q   <= 1'b0;
      w_r_q    <= 1'b0;
      retire_q <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      if (accept) instr_q <= bus.instr;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      off_q    <= off_d;
      opc_q    <= opc_d;
      sel1_q   <= sel1_d;
      sel3_q   <= sel3_d;
      w_r_q    <= w_r_d;
      retire_q <= retire_d;
      ready_q  <= ready_d;
      busy_q   <= ~ready_d;
    end
  end

  assign bus.operand1    = op1_q;
  assign bus.operand2    = op2_q;
  assign bus.offset      = off_q;
  assign bus.opcode      = opc_q;
  assign bus.sel1        = sel1_q;
  assign bus.sel3        = sel3_q;
  assign bus.w_r         = w_r_q;
  assign bus.retire      = retire_q;
  assign bus.instr_ready = ready_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_cu_multicycle_ctrl.sv
// Directed bench for cu_multicycle_ctrl at DATA_WIDTH=8, NUM_REGS=4; outputs sampled on negedge.
module tb_cu_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cu_multicycle_ctrl_if #(.DATA_WIDTH(8), .NUM_REGS(4)) bus ();

`ifdef CU_REGDBG_EN
  logic [1:0] dbg_addr;
  logic [7:0] dbg_data;
`endif

  cu_multicycle_ctrl #(.DATA_WIDTH(8), .NUM_REGS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus)
`ifdef CU_REGDBG_EN
    ,
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  // Present one word for a single cycle while idle; returns in the DECODE cycle.
  task automatic send(input logic [19:0] w);
    bus.instr_valid = 1'b1;
    bus.instr       = w;
    nxt();
    bus.instr_valid = 1'b0;
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, ".ready"},  32'(bus.instr_ready), 32'd1);
    chk({tag, ".busy"},   32'(bus.busy),        32'd0);
    chk({tag, ".opcode"}, 32'(bus.opcode),      32'hF);
    chk({tag, ".op1"},    32'(bus.operand1),    32'd0);
    chk({tag, ".op2"},    32'(bus.operand2),    32'd0);
    chk({tag, ".offset"}, 32'(bus.offset),      32'd0);
    chk({tag, ".sel1"},   32'(bus.sel1),        32'd0);
    chk({tag, ".sel3"},   32'(bus.sel3),        32'd0);
    chk({tag, ".w_r"},    32'(bus.w_r),         32'd0);
    chk({tag, ".retire"}, 32'(bus.retire),      32'd0);
  endtask

  initial begin
    rst             = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    bus.result2     = '0;
`ifdef CU_REGDBG_EN
    dbg_addr        = '0;
`endif
    nxt();
    nxt();
    idle_chk("reset");
    rst = 1'b0;
    nxt();

    // std_op dest3 src1=1 src2=2
    send(20'h76000);
    chk("std.dec.retire", 32'(bus.retire), 32'd0);
    chk("std.dec.busy",   32'(bus.busy),   32'd1);
    chk("std.dec.ready",  32'(bus.instr_ready), 32'd0);
    chk("std.dec.opcode", 32'(bus.opcode), 32'hF);
    nxt();
    chk("std.ex.op1",    32'(bus.operand1), 32'h01);
    chk("std.ex.op2",    32'(bus.operand2), 32'h02);
    chk("std.ex.sel1",   32'(bus.sel1),     32'd1);
    chk("std.ex.sel3",   32'(bus.sel3),     32'd0);
    chk("std.ex.opcode", 32'(bus.opcode),   32'h0);
    chk("std.ex.retire", 32'(bus.retire),   32'd0);
    bus.result2 = 8'h03;
    nxt();
    chk("std.wb.retire", 32'(bus.retire), 32'd1);
    chk("std.wb.w_r",    32'(bus.w_r),    32'd0);
    nxt();
    idle_chk("std.end");

    // loadR z=0 src1=1 offset=4
    send(20'h84040);
    chk("ld.dec.retire", 32'(bus.retire), 32'd0);
    nxt();
    chk("ld.ex.op1",    32'(bus.operand1), 32'h01);
    chk("ld.ex.op2",    32'(bus.operand2), 32'h00);
    chk("ld.ex.offset", 32'(bus.offset),   32'h04);
    chk("ld.ex.sel1",   32'(bus.sel1),     32'd0);
    chk("ld.ex.sel3",   32'(bus.sel3),     32'd1);
    chk("ld.ex.w_r",    32'(bus.w_r),      32'd0);
    nxt();
    chk("ld.mem.w_r",    32'(bus.w_r),    32'd0);
    chk("ld.mem.retire", 32'(bus.retire), 32'd0);
    bus.result2 = 8'hAA;
    nxt();
    chk("ld.wb.retire", 32'(bus.retire), 32'd1);
    chk("ld.wb.w_r",    32'(bus.w_r),    32'd0);
    nxt();
    idle_chk("ld.end");

    // storeR z=2 src1=1 offset=5; result2 driven with junk that must not land
    send(20'hE4050);
    nxt();
    chk("st.ex.op1",    32'(bus.operand1), 32'h01);
    chk("st.ex.op2",    32'(bus.operand2), 32'h02);
    chk("st.ex.offset", 32'(bus.offset),   32'h05);
    chk("st.ex.sel1",   32'(bus.sel1),     32'd1);
    chk("st.ex.sel3",   32'(bus.sel3),     32'd1);
    chk("st.ex.w_r",    32'(bus.w_r),      32'd0);
    nxt();
    chk("st.mem.w_r",    32'(bus.w_r),    32'd1);
    chk("st.mem.retire", 32'(bus.retire), 32'd0);
    bus.result2 = 8'hEE;
    nxt();
    chk("st.wb.w_r",    32'(bus.w_r),    32'd0);
    chk("st.wb.retire", 32'(bus.retire), 32'd1);
    nxt();
    idle_chk("st.end");

    // std_op dest3 src1=0 src2=3 op5, instr_valid held through busy
    bus.instr_valid = 1'b1;
    bus.instr       = 20'h73005;
    nxt();
    chk("b2b.a.dec.ready", 32'(bus.instr_ready), 32'd0);
    nxt();
    chk("b2b.a.ex.op1",    32'(bus.operand1), 32'hAA);
    chk("b2b.a.ex.op2",    32'(bus.operand2), 32'h03);
    chk("b2b.a.ex.opcode", 32'(bus.opcode),   32'h5);
    chk("b2b.a.ex.retire", 32'(bus.retire),   32'd0);
    bus.result2 = 8'h10;
    nxt();
    chk("b2b.a.wb.retire", 32'(bus.retire),      32'd1);
    chk("b2b.a.wb.ready",  32'(bus.instr_ready), 32'd0);
    nxt();
    chk("b2b.a.end.ready",  32'(bus.instr_ready), 32'd1);
    chk("b2b.a.end.retire", 32'(bus.retire),      32'd0);
    // std_op dest0 src1=3 src2=2 op1, accepted immediately
    bus.instr = 20'h4E001;
    nxt();
    bus.instr_valid = 1'b0;
    chk("b2b.b.dec.busy", 32'(bus.busy), 32'd1);
    nxt();
    chk("b2b.b.ex.op1",    32'(bus.operand1), 32'h10);
    chk("b2b.b.ex.op2",    32'(bus.operand2), 32'h02);
    chk("b2b.b.ex.opcode", 32'(bus.opcode),   32'h1);
    bus.result2 = 8'h55;
    nxt();
    chk("b2b.b.wb.retire", 32'(bus.retire), 32'd1);
    nxt();
    idle_chk("b2b.end");

    // NOP retires in its single DECODE cycle
    send(20'h00000);
    chk("nop.dec.retire", 32'(bus.retire),      32'd1);
    chk("nop.dec.busy",   32'(bus.busy),        32'd1);
    chk("nop.dec.ready",  32'(bus.instr_ready), 32'd0);
    chk("nop.dec.opcode", 32'(bus.opcode),      32'hF);
    chk("nop.dec.op1",    32'(bus.operand1),    32'h00);
    chk("nop.dec.sel1",   32'(bus.sel1),        32'd0);
    nxt();
    idle_chk("nop.end");
`ifdef CU_REGDBG_EN
    dbg_addr = 2'd2; #1;
    chk("dbg.r2", 32'(dbg_data), 32'h02);
    dbg_addr = 2'd0; #1;
    chk("dbg.r0", 32'(dbg_data), 32'h55);
    dbg_addr = 2'd3; #1;
    chk("dbg.r3", 32'(dbg_data), 32'h10);
`endif

    // Reset during storeR MEM_ACCESS
    send(20'hE4050);
    nxt();
    nxt();
    chk("rst.mem.w_r", 32'(bus.w_r), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst.async.w_r",    32'(bus.w_r),         32'd0);
    chk("rst.async.opcode", 32'(bus.opcode),      32'hF);
    chk("rst.async.ready",  32'(bus.instr_ready), 32'd1);
    chk("rst.async.busy",   32'(bus.busy),        32'd0);
    nxt();
    rst = 1'b0;
    idle_chk("rst.held");
`ifdef CU_REGDBG_EN
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i); #1;
      chk("rst.dbg", 32'(dbg_data), 32'(i));
    end
`endif
    nxt();
    // std_op dest1 src1=3 src2=0: both registers back at reset values
    send(20'h5C000);
    nxt();
    chk("rst.chk.op1", 32'(bus.operand1), 32'h03);
    chk("rst.chk.op2", 32'(bus.operand2), 32'h00);
    bus.result2 = 8'h99;
    nxt();
    chk("rst.chk.retire", 32'(bus.retire), 32'd1);
    nxt();
    idle_chk("rst.chk.end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
